regfile_mp: RTL and testbench

- Parametrised multi-port register file; next generation of the CPU's 2-read/1-write register file.
- Adds a configurable number of read ports and two prioritised write ports: ALU writeback and load writeback.
- Adds synchronous clear, optional write-to-read bypass and a per-register busy scoreboard for outstanding loads.
- Sits between decode (reads), writeback (writes) and the hazard unit (busy flags).

---
 rtl/regfile_mp.sv | 57 +++++
 tb/tb_regfile_mp.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with prioritised dual writeback, optional bypass and load busy scoreboard
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        waddr0,
    input  logic [DATA_W-1:0]        wdata0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        waddr1,
    input  logic [DATA_W-1:0]        wdata1,
    input  logic                     set_busy,
    input  logic [ADDR_W-1:0]        busy_addr,
    output logic [(1<<ADDR_W)-1:0]   busy_vec
);
    localparam int NUM_REGS = 1 << ADDR_W;
    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic                w0_ok, w1_ok, set_ok;
    // register 0 stays zero purely by gating its writes and muxing its reads
    assign w0_ok  = we0 && !(ZERO_REG && waddr0 == '0);
    assign w1_ok  = we1 && !(ZERO_REG && waddr1 == '0);
    assign set_ok = set_busy && !(ZERO_REG && busy_addr == '0);
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            busy <= '0;
        end else begin
            if (w0_ok) regs[waddr0] <= wdata0;
            if (w1_ok) begin
                regs[waddr1] <= wdata1;
                busy[waddr1] <= 1'b0;
            end
            // a set landing on the register just cleared wins: back-to-back load
            if (set_ok) busy[busy_addr] <= 1'b1;
        end
    end
    assign busy_vec = busy;
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              zero, hit0, hit1;
        assign ra   = rd_addr[k*ADDR_W +: ADDR_W];
        assign zero = ZERO_REG && ra == '0;
        assign hit1 = BYPASS && !rst && w1_ok && waddr1 == ra;
        assign hit0 = BYPASS && !rst && w0_ok && waddr0 == ra;
        assign rd_data[k*DATA_W +: DATA_W] = zero ? '0 : hit1 ? wdata1 : hit0 ? wdata0 : regs[ra];
        assign rd_busy[k] = !zero && !hit1 && busy[ra];
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized and directed checks of regfile_mp, bypass and non-bypass builds side by side
module tb_regfile_mp;
    localparam int DW = 32, AW = 5, NR = 4, NREG = 32;
    logic clk = 1'b0, rst = 1'b1;
    logic [NR*AW-1:0] rd_addr = '0;
    logic [NR*DW-1:0] rdb_data, rdn_data;
    logic [NR-1:0] rdb_busy, rdn_busy;
    logic we0 = 0, we1 = 0, set_busy = 0;
    logic [AW-1:0] waddr0 = 0, waddr1 = 0, busy_addr = 0;
    logic [DW-1:0] wdata0 = 0, wdata1 = 0;
    logic [NREG-1:0] bvb, bvn;
    int n_cmp = 0, n_bad = 0;
    logic [DW-1:0] mdl [NREG];
    logic [NREG-1:0] mbusy;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_b (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rdb_data), .rd_busy(rdb_busy),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0), .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .set_busy(set_busy), .busy_addr(busy_addr), .busy_vec(bvb));
    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_n (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rdn_data), .rd_busy(rdn_busy),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0), .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .set_busy(set_busy), .busy_addr(busy_addr), .busy_vec(bvn));

    // reference: architectural register values plus pending-load set, updated once per edge
    function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return '0;
        if (byp && !rst && we1 && waddr1 == a) return wdata1;
        if (byp && !rst && we0 && waddr0 == a) return wdata0;
        return mdl[a];
    endfunction
    function automatic logic exp_busy(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return 1'b0;
        if (byp && !rst && we1 && waddr1 == a) return 1'b0;
        return mbusy[a];
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < NREG; i++) mdl[i] = '0;
            mbusy = '0;
        end else begin
            if (we0 && waddr0 != 0) mdl[waddr0] = wdata0;
            if (we1 && waddr1 != 0) begin
                mdl[waddr1] = wdata1;
                mbusy[waddr1] = 1'b0;
            end
            if (set_busy && busy_addr != 0) mbusy[busy_addr] = 1'b1;
        end
        #1;
    endtask

    task automatic idle();
        we0 = 0; we1 = 0; set_busy = 0;
    endtask

    task automatic rand_in();
        logic [AW-1:0] lo;
        we0 = 1'($urandom); we1 = 1'($urandom); set_busy = 1'($urandom);
        lo = AW'($urandom_range(0, 7));
        waddr0 = $urandom_range(0, 1) ? lo : AW'($urandom);
        waddr1 = $urandom_range(0, 1) ? lo : AW'($urandom);
        busy_addr = $urandom_range(0, 1) ? lo : AW'($urandom);
        wdata0 = $urandom; wdata1 = $urandom;
        for (int k = 0; k < NR; k++) rd_addr[k*AW +: AW] = $urandom_range(0, 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
    endtask

    task automatic test_reset();
        rst = 0;
        for (int c = 0; c < 20; c++) begin rand_in(); tick(); end
        rst = 1;
        for (int c = 0; c < 2; c++) begin rand_in(); tick(); end
        rst = 0; idle();
        for (int r = 0; r < NREG; r += NR) begin
            for (int k = 0; k < NR; k++) rd_addr[k*AW +: AW] = AW'(r + k);
            #1;
            for (int k = 0; k < NR; k++) begin
                n_cmp++;
                if (rdb_data[k*DW +: DW] !== 0 || rdn_data[k*DW +: DW] !== 0 || rdb_busy[k] !== 0 || rdn_busy[k] !== 0) begin
                    n_bad++;
                    $display("FAIL reset reg%0d: got %h/%h busy %b/%b required 0", r + k, rdb_data[k*DW +: DW], rdn_data[k*DW +: DW], rdb_busy[k], rdn_busy[k]);
                end
            end
        end
        n_cmp++;
        if (bvb !== 0 || bvn !== 0) begin n_bad++; $display("FAIL reset busy_vec: got %h/%h required 0", bvb, bvn); end
    endtask

    task automatic test_bypass();
        rd_addr[0 +: AW] = 5; we0 = 1; waddr0 = 5; wdata0 = 32'hDEAD_BEEF; #1;
        n_cmp++;
        if (rdb_data[0 +: DW] !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL bypass same-cycle: got %h required deadbeef", rdb_data[0 +: DW]); end
        n_cmp++;
        if (rdn_data[0 +: DW] !== 0) begin n_bad++; $display("FAIL nobypass same-cycle: got %h required 0", rdn_data[0 +: DW]); end
        tick(); idle(); #1;
        n_cmp++;
        if (rdb_data[0 +: DW] !== 32'hDEAD_BEEF || rdn_data[0 +: DW] !== 32'hDEAD_BEEF) begin
            n_bad++; $display("FAIL write next-cycle: got %h/%h required deadbeef", rdb_data[0 +: DW], rdn_data[0 +: DW]);
        end
    endtask

    task automatic test_priority();
        rd_addr[AW +: AW] = 7; we0 = 1; waddr0 = 7; wdata0 = 32'h11; we1 = 1; waddr1 = 7; wdata1 = 32'h22; #1;
        n_cmp++;
        if (rdb_data[DW +: DW] !== 32'h22) begin n_bad++; $display("FAIL bypass priority: got %h required 22", rdb_data[DW +: DW]); end
        tick(); idle(); #1;
        n_cmp++;
        if (rdb_data[DW +: DW] !== 32'h22 || rdn_data[DW +: DW] !== 32'h22) begin
            n_bad++; $display("FAIL write priority: got %h/%h required 22", rdb_data[DW +: DW], rdn_data[DW +: DW]);
        end
    endtask

    task automatic test_zero();
        rd_addr[0 +: AW] = 0; we0 = 1; waddr0 = 0; wdata0 = '1; we1 = 1; waddr1 = 0; wdata1 = '1;
        set_busy = 1; busy_addr = 0; #1;
        n_cmp++;
        if (rdb_data[0 +: DW] !== 0 || rdn_data[0 +: DW] !== 0) begin n_bad++; $display("FAIL zero bypass: got %h/%h required 0", rdb_data[0 +: DW], rdn_data[0 +: DW]); end
        tick(); idle(); #1;
        n_cmp++;
        if (rdb_data[0 +: DW] !== 0 || rdn_data[0 +: DW] !== 0 || rdb_busy[0] !== 0) begin
            n_bad++; $display("FAIL zero write: got %h/%h busy %b required 0", rdb_data[0 +: DW], rdn_data[0 +: DW], rdb_busy[0]);
        end
        n_cmp++;
        if (bvb[0] !== 0 || bvn[0] !== 0) begin n_bad++; $display("FAIL zero busy_vec: got %b/%b required 0", bvb[0], bvn[0]); end
    endtask

    task automatic test_busy();
        rd_addr[0 +: AW] = 9; rd_addr[AW +: AW] = 9;
        set_busy = 1; busy_addr = 9; tick(); idle(); #1;
        n_cmp++;
        if (rdb_busy[1:0] !== 2'b11 || rdn_busy[1:0] !== 2'b11 || bvb[9] !== 1) begin
            n_bad++; $display("FAIL busy set: got %b/%b vec %b required 11/11 1", rdb_busy[1:0], rdn_busy[1:0], bvb[9]);
        end
        we1 = 1; waddr1 = 9; wdata1 = 32'h55; set_busy = 1; busy_addr = 9; #1;
        n_cmp++;
        if (rdb_busy[0] !== 0 || rdn_busy[0] !== 1 || rdb_data[0 +: DW] !== 32'h55) begin
            n_bad++; $display("FAIL busy load-return cycle: got busy %b/%b data %h required 0/1 55", rdb_busy[0], rdn_busy[0], rdb_data[0 +: DW]);
        end
        tick(); idle(); #1;
        n_cmp++;
        if (rdb_busy[0] !== 1 || rdn_busy[0] !== 1 || rdn_data[0 +: DW] !== 32'h55) begin
            n_bad++; $display("FAIL busy set-wins: got busy %b/%b data %h required 1/1 55", rdb_busy[0], rdn_busy[0], rdn_data[0 +: DW]);
        end
        we1 = 1; waddr1 = 9; wdata1 = 32'h66; tick(); idle(); #1;
        n_cmp++;
        if (rdb_busy[0] !== 0 || rdn_busy[0] !== 0 || bvn[9] !== 0) begin
            n_bad++; $display("FAIL busy clear: got %b/%b vec %b required 0", rdb_busy[0], rdn_busy[0], bvn[9]);
        end
    endtask

    task automatic test_ports();
        logic [DW-1:0] want [NR];
        want = '{32'hA, 32'hA, 32'hB, 32'hC};
        we0 = 1; waddr0 = 1; wdata0 = 32'hA; we1 = 1; waddr1 = 2; wdata1 = 32'hB; tick();
        we1 = 0; waddr0 = 31; wdata0 = 32'hC; tick(); idle();
        rd_addr = {AW'(31), AW'(2), AW'(1), AW'(1)}; #1;
        for (int k = 0; k < NR; k++) begin
            n_cmp++;
            if (rdb_data[k*DW +: DW] !== want[k] || rdn_data[k*DW +: DW] !== want[k]) begin
                n_bad++; $display("FAIL ports port%0d: got %h/%h required %h", k, rdb_data[k*DW +: DW], rdn_data[k*DW +: DW], want[k]);
            end
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] a;
        for (int c = 0; c < 600; c++) begin
            rand_in();
            rst = ($urandom_range(0, 59) == 0);
            #1;
            for (int k = 0; k < NR; k++) begin
                a = rd_addr[k*AW +: AW];
                n_cmp++;
                if (rdb_data[k*DW +: DW] !== exp_data(a, 1) || rdb_busy[k] !== exp_busy(a, 1)) begin
                    n_bad++; $display("FAIL random byp c%0d port%0d reg%0d: got %h/%b required %h/%b", c, k, a, rdb_data[k*DW +: DW], rdb_busy[k], exp_data(a, 1), exp_busy(a, 1));
                end
                n_cmp++;
                if (rdn_data[k*DW +: DW] !== exp_data(a, 0) || rdn_busy[k] !== exp_busy(a, 0)) begin
                    n_bad++; $display("FAIL random nobyp c%0d port%0d reg%0d: got %h/%b required %h/%b", c, k, a, rdn_data[k*DW +: DW], rdn_busy[k], exp_data(a, 0), exp_busy(a, 0));
                end
            end
            n_cmp++;
            if (bvb !== mbusy || bvn !== mbusy) begin n_bad++; $display("FAIL random busy_vec c%0d: got %h/%h required %h", c, bvb, bvn, mbusy); end
            tick();
        end
        rst = 0; idle();
    endtask

    initial begin
        for (int i = 0; i < NREG; i++) mdl[i] = '0;
        mbusy = '0;
        tick(); tick();
        test_reset();
        test_bypass();
        test_priority();
        test_zero();
        test_busy();
        test_ports();
        test_random();
        test_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
